cia_tod: RTL
============

Name: cia_tod

Overview:
- CIA-style 24-bit binary time-of-day counter. It consumes the 50/60 Hz tick produced by the tick-clock divider and sits directly downstream of it, inside U409.
- Synchronizes and edge-detects the tick, then counts ticks.
- Provides 8520-compatible halt-on-write and latch-on-read byte access, plus an alarm compare that raises a one-cycle interrupt pulse.

Parameters:
- SYNC_STAGES, 2, number of CLK6 flops in the tick synchronizer (minimum 2).
- TOD_WIDTH, 24, counter and alarm width; fixed at 24, exposed for the package/bench only.

Ports:
- CLK6  in  1  6 MHz system clock; the only clock.
- RESET  in  1  synchronous, active-high reset.
- TICK  in  1  50 or 60 Hz tick (square wave); asynchronous to CLK6.
- RS  in  2  byte select: 0=LO[7:0], 1=MID[15:8], 2=HI[23:16], 3=unused.
- WE  in  1  write strobe, one CLK6 cycle.
- RE  in  1  read strobe, one CLK6 cycle.
- ALARM_SEL  in  1  1: writes target the alarm register; 0: writes target the counter.
- DIN  in  8  write data.
- DOUT  out  8  read data, registered.
- IRQ_ALARM  out  1  one-cycle alarm match pulse.

Behaviour:
- Reset (synchronous, active-high) clears:
  - counter=0, alarm=0, halt=0, latched=0, snapshot=0;
  - DOUT=0x00, IRQ_ALARM=0;
  - synchronizer flops and edge-detect history=0.
- Reset asserted mid-operation aborts any halt or latch state immediately.
- Tick path:
  - TICK passes through SYNC_STAGES flops.
  - A rising edge of the synchronized signal yields tick_pulse, high for exactly one CLK6 cycle.
  - Latency from TICK rising to tick_pulse is SYNC_STAGES+1 cycles.
- Count:
  - On tick_pulse with halt=0, counter <= counter+1, modulo 2^24; 0xFFFFFF wraps to 0x000000.
  - A tick_pulse while halt=1 is dropped, not deferred.
- Counter writes (WE=1, ALARM_SEL=0):
  - RS=2: load HI byte, set halt=1.
  - RS=1: load MID byte.
  - RS=0: load LO byte, clear halt=0.
  - RS=3: ignored.
- Alarm writes (WE=1, ALARM_SEL=1):
  - Load the selected alarm byte.
  - halt is not affected.
- Same-cycle write and tick_pulse: the write wins and the tick is dropped, including when the write is to MID.
- Reads: DOUT is updated the cycle after RE=1.
  - RS=2 with latched=0: snapshot <= counter, latched <= 1, DOUT <= counter[23:16].
  - RS=1 and RS=0: return snapshot bytes if latched=1, else live counter bytes.
  - RS=0 read clears latched=0.
  - RS=3 returns 0x00.
  - A read never returns alarm contents.
  - The counter keeps running while latched.
- RE and WE in the same cycle: WE is serviced, RE is ignored, DOUT holds.
- Alarm:
  - The compare is evaluated only on a counter update (increment or counter-byte write).
  - If the updated value equals alarm, IRQ_ALARM=1 in the following cycle for one cycle.
  - Writing alarm equal to the current counter does not fire.
  - Reset (counter=alarm=0) does not fire; a wrap to 0 with alarm=0 fires.

Optional Feature:
- Macro: TOD_TICKSEL_EN.
- Defined:
  - Adds inputs TICK50 and TICK60 plus TICK_SEL (1 = TICK50) in place of TICK.
  - The mux is placed ahead of the synchronizer.
  - A change of TICK_SEL may generate at most one spurious tick_pulse.
- Undefined: single TICK input as listed under Ports.

Decomposition:
- cia_tod_pkg holds:
  - RS_LO=2'd0, RS_MID=2'd1, RS_HI=2'd2;
  - TOD_WIDTH=24;
  - reset constants for counter and alarm.
- One sub-module, tod_tick_sync: SYNC_STAGES-flop synchronizer with rising-edge pulse output. It is reused by the bench as a reference.

Test Plan:
- Reset, then 5 TICK rising edges with no register access -> LO read returns 0x05; exactly 5 tick_pulses, each SYNC_STAGES+1 cycles after its edge.
- Write HI=0x12, MID=0x34, apply 3 ticks, write LO=0x56, apply 1 tick -> counter=0x123457 (the 3 ticks are dropped).
- Counter=0x0000FF; read HI, apply 2 ticks, read MID, read LO -> 0x00, 0x00, 0xFF; a subsequent LO read returns the live value 0x01.
- Counter=0xFFFFFF, alarm=0x000000, 1 tick -> counter=0x000000; IRQ_ALARM high for exactly 1 cycle.
- Write LO=0x10 coincident with tick_pulse -> counter LO=0x10, not 0x11; RE+WE same cycle leaves DOUT unchanged.
- Set halt and latched, assert RESET for 1 cycle -> all state cleared; DOUT=0x00; the next tick counts to 0x000001.

Source files
------------

// File: rtl/cia_tod_pkg.sv
// Shared constants and byte-access helpers for the CIA-style time-of-day counter.
package cia_tod_pkg;

   localparam int TOD_WIDTH = 24;

   localparam logic [1:0] RS_LO   = 2'd0;
   localparam logic [1:0] RS_MID  = 2'd1;
   localparam logic [1:0] RS_HI   = 2'd2;
   localparam logic [1:0] RS_NONE = 2'd3;

   typedef logic [TOD_WIDTH-1:0] tod_t;

   localparam tod_t TOD_COUNTER_RST = '0;
   localparam tod_t TOD_ALARM_RST   = '0;

   function automatic logic [7:0] tod_byte(input tod_t v, input logic [1:0] rs);
      case (rs)
         RS_LO:   return v[7:0];
         RS_MID:  return v[15:8];
         RS_HI:   return v[23:16];
         default: return 8'h00;
      endcase
   endfunction

   function automatic tod_t tod_set_byte(input tod_t v, input logic [1:0] rs,
                                         input logic [7:0] data);
      tod_t r;
      r = v;
      case (rs)
         RS_LO:   r[7:0]   = data;
         RS_MID:  r[15:8]  = data;
         RS_HI:   r[23:16] = data;
         default: r = v;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/tod_tick_sync.sv
// Multi-flop synchronizer for the asynchronous mains tick plus a registered
// rising-edge pulse; pulse appears SYNC_STAGES+1 clocks after the input rises.
module tod_tick_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic tick_i,
   output logic pulse_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   pulse_q;

   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q  <= '0;
         hist_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], tick_i};
         hist_q  <= sync_q[SYNC_STAGES-1];
         pulse_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/cia_tod.sv
// 24-bit binary time-of-day counter with 8520-style halt-on-write, latch-on-read
// and alarm pulse. Define TOD_TICKSEL_EN to select between TICK50/TICK60 inputs.
module cia_tod
   import cia_tod_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       CLK6,
   input  logic       RESET,
`ifdef TOD_TICKSEL_EN
   input  logic       TICK50,
   input  logic       TICK60,
   input  logic       TICK_SEL,
`else
   input  logic       TICK,
`endif
   input  logic [1:0] RS,
   input  logic       WE,
   input  logic       RE,
   input  logic       ALARM_SEL,
   input  logic [7:0] DIN,
   output logic [7:0] DOUT,
   output logic       IRQ_ALARM
);

   logic tick_src;
   logic tick_pulse;

`ifdef TOD_TICKSEL_EN
   assign tick_src = TICK_SEL ? TICK50 : TICK60;
`else
   assign tick_src = TICK;
`endif

   tod_tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tick_sync (
      .clk_i   (CLK6),
      .rst_i   (RESET),
      .tick_i  (tick_src),
      .pulse_o (tick_pulse)
   );

   tod_t       counter_q, counter_d;
   tod_t       alarm_q, alarm_d;
   tod_t       snapshot_q, snapshot_d;
   logic       halt_q, halt_d;
   logic       latched_q, latched_d;
   logic [7:0] dout_q, dout_d;
   logic       irq_q, irq_d;
   logic       cnt_upd;
   logic       ctr_wr;
   logic       rd_en;

   assign ctr_wr = WE && !ALARM_SEL && (RS != RS_NONE);
   assign rd_en  = RE && !WE;

   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      counter_d  = counter_q;
      alarm_d    = alarm_q;
      snapshot_d = snapshot_q;
      halt_d     = halt_q;
      latched_d  = latched_q;
      dout_d     = dout_q;
      cnt_upd    = 1'b0;

      // A counter write takes priority over a coincident tick, which is then lost.
      if (ctr_wr) begin
         counter_d = tod_set_byte(counter_q, RS, DIN);
         cnt_upd   = 1'b1;
         if (RS == RS_HI) halt_d = 1'b1;
         else if (RS == RS_LO) halt_d = 1'b0;
      end else if (tick_pulse && !halt_q) begin
         counter_d = counter_q + TOD_WIDTH'(1);
         cnt_upd   = 1'b1;
      end

      if (WE && ALARM_SEL) alarm_d = tod_set_byte(alarm_q, RS, DIN);

      if (rd_en) begin
         if (RS == RS_HI && !latched_q) begin
            snapshot_d = counter_q;
            latched_d  = 1'b1;
            dout_d     = counter_q[23:16];
         end else begin
            dout_d = tod_byte(latched_q ? snapshot_q : counter_q, RS);
            if (RS == RS_LO) latched_d = 1'b0;
         end
      end

      irq_d = cnt_upd && (counter_d == alarm_q);
   end

   always_ff @(posedge CLK6) begin
      if (RESET) begin
         // NOTE: snapshot is cleared too, so no stale counter bytes survive a reset.
         counter_q  <= TOD_COUNTER_RST;
         alarm_q    <= TOD_ALARM_RST;
         snapshot_q <= TOD_COUNTER_RST;
         halt_q     <= 1'b0;
         latched_q  <= 1'b0;
         dout_q     <= 8'h00;
         irq_q      <= 1'b0;
      end else begin
         counter_q  <= counter_d;
         alarm_q    <= alarm_d;
         snapshot_q <= snapshot_d;
         halt_q     <= halt_d;
         latched_q  <= latched_d;
         dout_q     <= dout_d;
         irq_q      <= irq_d;
      end
   end

   assign DOUT      = dout_q;
   assign IRQ_ALARM = irq_q;

endmodule
